// File: rtl/turn_controller_if.sv
// turn_controller_if: game-control handshake between the board logic and the turn controller
interface turn_controller_if;
    logic       start_i;
    logic       move_done_i;
    logic       win_detected_i;
    logic       board_full_i;
    logic       game_active_o;
    logic       current_player_o;
    logic [4:0] secs_left_o;
    logic       timeout_o;
    logic       game_over_o;
    logic [1:0] winner_o;

    modport master (
        output start_i, move_done_i, win_detected_i, board_full_i,
        input  game_active_o, current_player_o, secs_left_o, timeout_o, game_over_o, winner_o
    );

    modport slave (
        input  start_i, move_done_i, win_detected_i, board_full_i,
        output game_active_o, current_player_o, secs_left_o, timeout_o, game_over_o, winner_o
    );
endinterface

// File: rtl/turn_controller.sv
// turn_controller: two-player turn sequencing with a per-turn countdown and win/draw resolution
module turn_controller #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    turn_controller_if.slave  bus
);
    localparam int             PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRE_MAX   = PW'(CLK_HZ - 1);
    localparam logic [4:0]     SECS_INIT = 5'(TURN_SECONDS);

    typedef enum logic [1:0] {IDLE, PLAY, EVAL, OVER} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [4:0]    secs_q, secs_d;
    logic          player_q, player_d;
    logic          timeout_q, timeout_d;
    logic [1:0]    winner_q, winner_d;
    logic          active_q, active_d;
    logic          over_q, over_d;

    // State and output registers; reset discards all game state immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            secs_q    <= SECS_INIT;
            player_q  <= 1'b0;
            timeout_q <= 1'b0;
            winner_q  <= 2'b00;
            active_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            secs_q    <= secs_d;
            player_q  <= player_d;
            timeout_q <= timeout_d;
            winner_q  <= winner_d;
            active_q  <= active_d;
            over_q    <= over_d;
        end
    end

    // Next state: a committed move always beats a coinciding tick, and secs_left reloads instead of reaching 0
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        secs_d    = secs_q;
        player_d  = player_q;
        timeout_d = 1'b0;
        winner_d  = winner_q;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start_i) begin
                    state_d  = PLAY;
                    pre_d    = '0;
                    secs_d   = SECS_INIT;
                    player_d = 1'b0;
                    winner_d = 2'b00;
                end
            end
            PLAY: begin
                if (bus.move_done_i) begin
                    state_d = EVAL;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    if (secs_q > 5'd1) begin
                        secs_d = secs_q - 5'd1;
                    end else begin
                        timeout_d = 1'b1;
                        player_d  = ~player_q;
                        secs_d    = SECS_INIT;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            EVAL: begin
                if (bus.win_detected_i) begin
                    state_d  = OVER;
                    winner_d = player_q ? 2'b10 : 2'b01;
                end else if (bus.board_full_i) begin
                    state_d  = OVER;
                    winner_d = 2'b11;
                end else begin
                    state_d  = PLAY;
                    player_d = ~player_q;
                    secs_d   = SECS_INIT;
                    pre_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d == PLAY) || (state_d == EVAL);
        over_d   = (state_d == OVER);
    end

    assign bus.game_active_o    = active_q;
    assign bus.current_player_o = player_q;
    assign bus.secs_left_o      = secs_q;
    assign bus.timeout_o        = timeout_q;
    assign bus.game_over_o      = over_q;
    assign bus.winner_o         = winner_q;
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed scenarios against an elapsed-time reference model of the turn rules
module tb_turn_controller;
    localparam int C = 4;
    localparam int T = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    turn_controller_if bus ();

    turn_controller #(.CLK_HZ(C), .TURN_SECONDS(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 play, 2 eval, 3 over; time tracked as cycles elapsed in the turn
    int m_phase = 0;
    int m_player = 0;
    int m_el = 0;
    int m_winner = 0;
    int m_to = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_player = 0; m_el = 0; m_winner = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_phase == 0 || m_phase == 3) begin
                if (bus.start_i) begin
                    m_phase = 1; m_player = 0; m_el = 0; m_winner = 0;
                end
            end else if (m_phase == 1) begin
                if (bus.move_done_i) m_phase = 2;
                else begin
                    m_el = m_el + 1;
                    if (m_el == T * C) begin
                        m_to = 1; m_player = 1 - m_player; m_el = 0;
                    end
                end
            end else begin
                if (bus.win_detected_i) begin
                    m_phase = 3; m_winner = m_player + 1;
                end else if (bus.board_full_i) begin
                    m_phase = 3; m_winner = 3;
                end else begin
                    m_phase = 1; m_player = 1 - m_player; m_el = 0;
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, e, $time);
        end
    endtask

    // Every cycle, compare all outputs against the model away from the active edge
    always @(negedge clk) begin
        chk("m_active", 32'(bus.game_active_o), 32'(m_phase == 1 || m_phase == 2));
        chk("m_player", 32'(bus.current_player_o), 32'(m_player));
        chk("m_secs", 32'(bus.secs_left_o), 32'(T - m_el / C));
        chk("m_timeout", 32'(bus.timeout_o), 32'(m_to));
        chk("m_over", 32'(bus.game_over_o), 32'(m_phase == 3));
        chk("m_winner", 32'(bus.winner_o), 32'(m_winner));
    end

    task automatic step(input logic s, input logic m, input logic w, input logic f);
        bus.start_i        = s;
        bus.move_done_i    = m;
        bus.win_detected_i = w;
        bus.board_full_i   = f;
        @(negedge clk);
        bus.start_i     = 1'b0;
        bus.move_done_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.move_done_i = 1'b0;
        bus.win_detected_i = 1'b0;
        bus.board_full_i = 1'b0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_active", 32'(bus.game_active_o), 0);
        chk("rst_secs", 32'(bus.secs_left_o), 3);
        chk("rst_winner", 32'(bus.winner_o), 0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_active", 32'(bus.game_active_o), 1);
        chk("start_player", 32'(bus.current_player_o), 0);
        chk("start_secs", 32'(bus.secs_left_o), 3);
        idle(4);
        chk("tick1_secs", 32'(bus.secs_left_o), 2);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(6);
        chk("last_sec", 32'(bus.secs_left_o), 1);
        chk("no_early_to", 32'(bus.timeout_o), 0);
        idle(1);
        chk("to_pulse", 32'(bus.timeout_o), 1);
        chk("to_player", 32'(bus.current_player_o), 1);
        chk("to_secs", 32'(bus.secs_left_o), 3);
        idle(1);
        chk("to_single", 32'(bus.timeout_o), 0);
        idle(11);
        chk("to2_player", 32'(bus.current_player_o), 0);

        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("eval_active", 32'(bus.game_active_o), 1);
        chk("eval_secs", 32'(bus.secs_left_o), 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mv_player", 32'(bus.current_player_o), 1);
        chk("mv_secs", 32'(bus.secs_left_o), 3);
        idle(3);
        chk("mv_presc", 32'(bus.secs_left_o), 3);
        idle(1);
        chk("mv_tick", 32'(bus.secs_left_o), 2);

        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("win_over", 32'(bus.game_over_o), 1);
        chk("win_active", 32'(bus.game_active_o), 0);
        chk("win_winner", 32'(bus.winner_o), 2);
        chk("win_player", 32'(bus.current_player_o), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("over_hold", 32'(bus.game_over_o), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_winner", 32'(bus.winner_o), 0);
        chk("restart_player", 32'(bus.current_player_o), 0);
        chk("restart_active", 32'(bus.game_active_o), 1);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("draw_winner", 32'(bus.winner_o), 3);
        chk("draw_player", 32'(bus.current_player_o), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(11);
        chk("fin_secs", 32'(bus.secs_left_o), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("fin_no_to", 32'(bus.timeout_o), 0);
        chk("fin_freeze", 32'(bus.secs_left_o), 1);
        chk("fin_player", 32'(bus.current_player_o), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fin_toggle", 32'(bus.current_player_o), 1);
        chk("fin_reload", 32'(bus.secs_left_o), 3);

        idle(5);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_active", 32'(bus.game_active_o), 0);
        chk("arst_player", 32'(bus.current_player_o), 0);
        chk("arst_secs", 32'(bus.secs_left_o), 3);
        chk("arst_winner", 32'(bus.winner_o), 0);
        bus.start_i = 1'b1;
        @(negedge clk);
        chk("arst_start_ign", 32'(bus.game_active_o), 0);
        bus.start_i = 1'b0;
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_idle", 32'(bus.game_active_o), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_play", 32'(bus.game_active_o), 1);
        idle(4);
        chk("post_rst_tick", 32'(bus.secs_left_o), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, giving clock cycles per one-second tick.
REQ-002 The block SHALL have parameter TURN_SECONDS, default 10, giving per-turn time budget; legal range 1..31.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  synchronous single-cycle pulse, start or restart game.
REQ-006 The block SHALL have port move_done  input  1  synchronous single-cycle pulse, active player committed a legal move.
REQ-007 The block SHALL have port win_detected  input  1  level, board holds a winning line for the mover; sampled only in EVAL.
REQ-008 The block SHALL have port board_full  input  1  level, no empty cell remains; sampled only in EVAL.
REQ-009 The block SHALL have port game_active  output  1  high in PLAY and EVAL; drives turn LEDs.
REQ-010 The block SHALL have port current_player  output  1  0 = P1, 1 = P2.
REQ-011 The block SHALL have port secs_left  output  5  remaining seconds of the current turn.
REQ-012 The block SHALL have port timeout  output  1  single-cycle pulse when a turn expires.
REQ-013 The block SHALL have port game_over  output  1  high in OVER only.
REQ-014 The block SHALL have port winner  output  2  00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-015 The block SHALL implement states IDLE, PLAY, EVAL, OVER, all outputs registered.
REQ-016 In IDLE, start SHALL move to PLAY: current_player=0, secs_left=TURN_SECONDS, prescaler=0, winner=00.
REQ-017 In PLAY, the prescaler SHALL count 0..CLK_HZ-1 and wrap; the wrap cycle is the tick.
REQ-018 On a tick with secs_left>1, secs_left SHALL decrement by 1.
REQ-019 On a tick with secs_left==1, the block SHALL assert timeout for exactly one cycle, toggle current_player, reload secs_left=TURN_SECONDS, remain in PLAY; secs_left never reads 0.
REQ-020 In PLAY, move_done SHALL move to EVAL on the next edge; the prescaler and secs_left freeze in EVAL.
REQ-021 move_done and a timeout tick in the same cycle: move_done SHALL win; no timeout pulse, no decrement.
REQ-022 EVAL SHALL last exactly one cycle and then, by priority: win_detected -> OVER with winner = current_player+1 (01/10); else board_full -> OVER with winner=11; else toggle current_player, reload secs_left, clear prescaler, return to PLAY.
REQ-023 current_player SHALL NOT change on entry to OVER; it holds the last mover.
REQ-024 In OVER, start SHALL begin a new game identically to REQ-016.
REQ-025 start in PLAY or EVAL SHALL be ignored.
REQ-026 move_done outside PLAY SHALL be ignored; win_detected and board_full outside EVAL SHALL be ignored.
REQ-027 The prescaler SHALL be wide enough for CLK_HZ-1 with no truncation; secs_left arithmetic SHALL never underflow.

Reset
REQ-028 Asserting rst_n low SHALL, immediately and regardless of clk, force IDLE, current_player=0, secs_left=TURN_SECONDS, prescaler=0, game_active=0, timeout=0, game_over=0, winner=00.
REQ-029 Reset mid-game (PLAY, EVAL or OVER) SHALL discard all game state; release returns to IDLE awaiting start.

Verification (CLK_HZ=4, TURN_SECONDS=3)
REQ-030 Reset then start -> next cycle game_active=1, current_player=0, secs_left=3; after 4 cycles secs_left=2.
REQ-031 No moves after start -> after 12 cycles one-cycle timeout pulse, current_player=1, secs_left=3; after 12 more, current_player=0.
REQ-032 move_done in PLAY with win_detected=0, board_full=0 -> one EVAL cycle, then current_player toggled, secs_left=3, prescaler restarted.
REQ-033 P2 move_done with win_detected=1 -> game_over=1, game_active=0, winner=10; further move_done ignored; start -> PLAY, winner=00, current_player=0.
REQ-034 move_done with board_full=1, win_detected=0 -> winner=11; move_done coinciding with final tick at secs_left=1 -> no timeout pulse, EVAL entered.
REQ-035 rst_n asserted mid-PLAY between clock edges -> outputs reach reset values without a clock edge; start ignored while rst_n low.
